risc16_seq_ctrl: RTL

Multi-cycle control sequencer for the non-pipelined RiSC-16 core. It latches the word presented by the fetch stage and walks each instruction through FETCH/EXEC/MEM/WB. It drives the fetch stage's PC-select, the ALU and register-file controls, and a request/ready handshake to data memory. It also detects HALT, flags memory timeouts and counts retired instructions.

---
 rtl/risc16_seq_ctrl_pkg.sv | 69 ++++++
 rtl/risc16_seq_ctrl_decode.sv | 73 +++++++
 rtl/risc16_seq_ctrl.sv | 124 ++++++++++++
 3 files changed

// File: rtl/risc16_seq_ctrl_pkg.sv
// Shared encodings for the RiSC-16 multi-cycle sequencer: opcodes, mux selects,
// ALU ops, FSM states and the control-vector payload.
package risc16_seq_ctrl_pkg;

  localparam int unsigned DEF_WORD_LEN = 16;
  localparam int unsigned OPC_W        = 3;
  localparam int unsigned IMM7_W       = 7;

  typedef enum logic [2:0] {
    OP_ADD  = 3'd0,
    OP_ADDI = 3'd1,
    OP_NAND = 3'd2,
    OP_LUI  = 3'd3,
    OP_SW   = 3'd4,
    OP_LW   = 3'd5,
    OP_BEQ  = 3'd6,
    OP_JALR = 3'd7
  } opcode_e;

  typedef enum logic [1:0] {
    SEL_PC_NPC    = 2'd0,
    SEL_PC_BRANCH = 2'd1,
    SEL_PC_ALU    = 2'd2,
    SEL_PC_HOLD   = 2'd3
  } pc_sel_e;

  typedef enum logic [1:0] {
    ALU_ADD    = 2'd0,
    ALU_NAND   = 2'd1,
    ALU_PASS_A = 2'd2,
    ALU_PASS_B = 2'd3
  } alu_op_e;

  typedef enum logic [1:0] {
    SEL_B_REG   = 2'd0,
    SEL_B_SIMM7 = 2'd1,
    SEL_B_IMM10 = 2'd2
  } b_sel_e;

  typedef enum logic [1:0] {
    SEL_WD_ALU = 2'd0,
    SEL_WD_MEM = 2'd1,
    SEL_WD_NPC = 2'd2
  } wd_sel_e;

  typedef enum logic [2:0] {
    ST_FETCH = 3'd0,
    ST_EXEC  = 3'd1,
    ST_MEM   = 3'd2,
    ST_WB    = 3'd3,
    ST_HALT  = 3'd4
  } state_e;

  typedef struct packed {
    pc_sel_e mux_pc;
    alu_op_e alu_op;
    b_sel_e  mux_alu_b;
    wd_sel_e mux_rf_wdata;
    logic    rf_we;
    logic    mem_req;
    logic    mem_we;
  } ctrl_t;

  // JALR with a non-zero immediate is the HALT encoding.
  function automatic logic is_halt(input opcode_e op, input logic [IMM7_W-1:0] imm7);
    return (op == OP_JALR) && (imm7 != '0);
  endfunction

endpackage

// File: rtl/risc16_seq_ctrl_decode.sv
// Combinational control decode: FSM state + latched instruction fields -> control vector.
module risc16_decode
  import risc16_seq_ctrl_pkg::*;
(
  input  state_e            state,
  input  opcode_e           opcode,
  input  logic [IMM7_W-1:0] imm7,
  input  logic              alu_eq,
  input  logic              mem_ready,
  output ctrl_t             ctrl
);

  always_comb begin
    ctrl = '{mux_pc: SEL_PC_HOLD, alu_op: ALU_ADD, mux_alu_b: SEL_B_REG,
             mux_rf_wdata: SEL_WD_ALU, rf_we: 1'b0, mem_req: 1'b0, mem_we: 1'b0};
    case (state)
      ST_EXEC: begin
        case (opcode)
          OP_ADD: begin
            ctrl.rf_we  = 1'b1;
            ctrl.mux_pc = SEL_PC_NPC;
          end
          OP_ADDI: begin
            ctrl.mux_alu_b = SEL_B_SIMM7;
            ctrl.rf_we     = 1'b1;
            ctrl.mux_pc    = SEL_PC_NPC;
          end
          OP_NAND: begin
            ctrl.alu_op = ALU_NAND;
            ctrl.rf_we  = 1'b1;
            ctrl.mux_pc = SEL_PC_NPC;
          end
          OP_LUI: begin
            ctrl.alu_op    = ALU_PASS_B;
            ctrl.mux_alu_b = SEL_B_IMM10;
            ctrl.rf_we     = 1'b1;
            ctrl.mux_pc    = SEL_PC_NPC;
          end
          OP_BEQ: begin
            ctrl.mux_pc = alu_eq ? SEL_PC_BRANCH : SEL_PC_NPC;
          end
          OP_JALR: begin
            // HALT form leaves everything idle.
            if (!is_halt(opcode, imm7)) begin
              ctrl.alu_op       = ALU_PASS_A;
              ctrl.mux_rf_wdata = SEL_WD_NPC;
              ctrl.rf_we        = 1'b1;
              ctrl.mux_pc       = SEL_PC_ALU;
            end
          end
          OP_SW, OP_LW: begin
            ctrl.mux_alu_b = SEL_B_SIMM7;
          end
          default: ;
        endcase
      end
      ST_MEM: begin
        // Address held on the ALU for the whole memory access.
        ctrl.mux_alu_b = SEL_B_SIMM7;
        ctrl.mem_req   = 1'b1;
        ctrl.mem_we    = (opcode == OP_SW);
        if (mem_ready && (opcode == OP_SW)) ctrl.mux_pc = SEL_PC_NPC;
      end
      ST_WB: begin
        ctrl.mux_rf_wdata = SEL_WD_MEM;
        ctrl.rf_we        = 1'b1;
        ctrl.mux_pc       = SEL_PC_NPC;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/risc16_seq_ctrl.sv
// RiSC-16 multi-cycle sequencer: FETCH/EXEC/MEM/WB FSM, memory timeout,
// HALT detection and retired-instruction counter.
module risc16_seq_ctrl
  import risc16_seq_ctrl_pkg::*;
#(
  parameter int unsigned WORD_LEN    = DEF_WORD_LEN,
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [WORD_LEN-1:0] instr,
  input  logic                alu_eq,
  input  logic                mem_ready,
  output logic [1:0]          mux_pc,
  output logic [1:0]          alu_op,
  output logic [1:0]          mux_alu_b,
  output logic [1:0]          mux_rf_wdata,
  output logic                rf_we,
  output logic                mem_req,
  output logic                mem_we,
  output logic                halted,
  output logic                err,
  output logic [CNT_W-1:0]    retired
);

  localparam int unsigned WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

  state_e              state, state_next;
  logic [WORD_LEN-1:0] ir, ir_next;
  logic [WAIT_W-1:0]   wait_cnt, wait_next;
  logic [CNT_W-1:0]    retired_next;
  logic                halted_next, err_next;

  opcode_e           opcode;
  logic [IMM7_W-1:0] imm7;
  logic              unused_ir_bits;
  ctrl_t             ctrl;
  logic              retire_c;

  assign opcode         = opcode_e'(ir[WORD_LEN-1 -: OPC_W]);
  assign imm7           = ir[IMM7_W-1:0];
  assign unused_ir_bits = ^ir[WORD_LEN-OPC_W-1:IMM7_W];

  risc16_decode u_decode (
    .state     (state),
    .opcode    (opcode),
    .imm7      (imm7),
    .alu_eq    (alu_eq),
    .mem_ready (mem_ready),
    .ctrl      (ctrl)
  );

  assign mux_pc       = ctrl.mux_pc;
  assign alu_op       = ctrl.alu_op;
  assign mux_alu_b    = ctrl.mux_alu_b;
  assign mux_rf_wdata = ctrl.mux_rf_wdata;
  assign rf_we        = ctrl.rf_we;
  assign mem_req      = ctrl.mem_req;
  assign mem_we       = ctrl.mem_we;

  // HALT retires on its EXEC cycle even though the PC stays put.
  assign retire_c = (ctrl.mux_pc != SEL_PC_HOLD) ||
                    ((state == ST_EXEC) && is_halt(opcode, imm7));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_FETCH;
      ir       <= '0;
      wait_cnt <= '0;
      retired  <= '0;
      halted   <= 1'b0;
      err      <= 1'b0;
    end else begin
      state    <= state_next;
      ir       <= ir_next;
      wait_cnt <= wait_next;
      retired  <= retired_next;
      halted   <= halted_next;
      err      <= err_next;
    end
  end

  always_comb begin
    state_next   = state;
    ir_next      = ir;
    wait_next    = wait_cnt;
    halted_next  = halted;
    err_next     = err;
    retired_next = (retire_c && (retired != '1)) ? retired + CNT_W'(1) : retired;
    case (state)
      ST_FETCH: begin
        ir_next    = instr;
        state_next = ST_EXEC;
      end
      ST_EXEC: begin
        if ((opcode == OP_SW) || (opcode == OP_LW)) begin
          wait_next  = '0;
          state_next = ST_MEM;
        end else if (is_halt(opcode, imm7)) begin
          halted_next = 1'b1;
          state_next  = ST_HALT;
        end else begin
          state_next = ST_FETCH;
        end
      end
      ST_MEM: begin
        if (mem_ready) begin
          state_next = (opcode == OP_SW) ? ST_FETCH : ST_WB;
        end else if (wait_cnt == WAIT_W'(MEM_TIMEOUT - 1)) begin
          err_next    = 1'b1;
          halted_next = 1'b1;
          state_next  = ST_HALT;
        end else begin
          wait_next = wait_cnt + WAIT_W'(1);
        end
      end
      ST_WB:   state_next = ST_FETCH;
      ST_HALT: state_next = ST_HALT;
      default: state_next = ST_FETCH;
    endcase
  end

endmodule
